id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode stage of the 5-stage MIPS pipeline, sitting between the IF/ID register and the ALU/EX stage.
- Takes the fetched instruction and drives the register-file read addresses combinationally. It captures the returned operands, which already include the register file's write-through bypass.
- Decodes control, sign-extends the immediate, detects load-use hazards and registers everything into the ID/EX pipeline register.
- Owns the stall request to fetch and the bubble/flush insertion into EX.

Parameters:
- DATA_W, 32, datapath and instruction width.
- REG_AW, 5, register address width (32 registers; $0 hardwired zero).
- STALL_CNT_W, 16, width of the saturating load-use stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_instr  in  32  instruction word from IF/ID.
- id_pc_plus4  in  32  PC+4 of that instruction.
- flush  in  1  branch-taken squash from EX; kills the instruction entering ID/EX.
- rf_read_reg1  out  5  rs field (id_instr[25:21]); combinational.
- rf_read_reg2  out  5  rt field (id_instr[20:16]); combinational.
- rf_read_data1  in  32  register-file data for rs (already write-through bypassed).
- rf_read_data2  in  32  register-file data for rt.
- stall  out  1  hold PC and IF/ID this cycle; combinational.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_pc_plus4  out  32  registered PC+4.
- ex_rs_data  out  32  registered rs operand.
- ex_rt_data  out  32  registered rt operand.
- ex_imm  out  32  sign-extended id_instr[15:0].
- ex_rs  out  5  rs address, for EX forwarding.
- ex_rt  out  5  rt address, for EX forwarding.
- ex_dest  out  5  destination register (0 when no write).
- ex_funct  out  6  id_instr[5:0].
- ex_alu_op  out  2  00 add, 01 sub (beq), 10 R-type funct.
- ex_alu_src  out  1  1 selects ex_imm as ALU B.
- ex_reg_write  out  1  write-back enable.
- ex_mem_read  out  1  load.
- ex_mem_write  out  1  store.
- ex_branch  out  1  beq.
- ex_illegal  out  1  unsupported opcode.
- stall_count  out  16  saturating count of stall cycles.

Behaviour:
- Reset: all ex_* outputs and stall_count are 0 asynchronously on rst_n low, including mid-operation. The first rising edge after rst_n deasserts behaves normally.
- Decode by opcode id_instr[31:26]:
  - 0x00 R-type: dest=rd, reg_write=1, alu_op=10, alu_src=0, rt used.
  - 0x23 lw: dest=rt, reg_write=1, mem_read=1, alu_op=00, alu_src=1, rt not used.
  - 0x2B sw: dest=0, mem_write=1, alu_op=00, alu_src=1, rt used.
  - 0x04 beq: dest=0, branch=1, alu_op=01, alu_src=0, rt used.
  - 0x08 addi: dest=rt, reg_write=1, alu_op=00, alu_src=1, rt not used.
  - Any other opcode: all controls 0, dest=0, illegal=1, still valid.
  - Any decode yielding dest=0: reg_write is forced to 0.
- Hazard (combinational): stall = id_valid & ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==rs | (rt used & ex_dest==rt)).
- ID/EX update each rising edge, priority flush > stall > normal:
  - flush: bubble (ex_valid and all control bits 0; data fields don't-care, driven 0).
  - stall: bubble into ID/EX. stall_count increments, saturating at 0xFFFF. IF/ID holds externally, so the same instruction re-decodes next cycle.
  - normal with id_valid=1: capture decoded fields, operands and PC+4.
  - normal with id_valid=0: bubble.
- stall is not gated by flush; fetch arbitrates flush over stall.
- Latency: one cycle from IF/ID to ID/EX. Load-use costs exactly one bubble. After the bubble, the dependent instruction's operand comes from EX/MEM/WB forwarding or the register-file write-through.
- ex_imm = {{16{instr[15]}}, instr[15:0]} for all opcodes.
- rf_read_reg1/2 are driven from id_instr regardless of id_valid.

Decomposition:
- Shared package mips_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI), ALU_OP_* encodings, instruction field bit positions, and the control-bundle struct also used by EX/MEM.
- One sub-module, control_decode: purely combinational opcode to control bundle plus rt_used and illegal.
- Hazard logic and pipeline register stay in id_ex_stage.

Test Plan:
- Reset: hold rst_n=0 with id_valid=1 and instr add $3,$1,$2 -> all ex_* =0, stall_count=0. Release rst_n -> next edge ex_valid=1, ex_dest=3, ex_reg_write=1, ex_alu_op=10.
- Decode: addi $5,$0,-4 (0x2005FFFC) -> ex_imm=0xFFFFFFFC, ex_dest=5, ex_alu_src=1. Then sw $5,8($1) -> ex_mem_write=1, ex_reg_write=0, ex_dest=0.
- Load-use: lw $4,0($1) followed by add $6,$4,$2 -> stall=1 for exactly one cycle, one ex_valid=0 bubble, stall_count=1, then the add issues with ex_rs=4. The pair lw $4 then addi $7,$8,1 -> no stall.
- Load to $0: lw $0,0($1) then add $6,$0,$0 -> no stall, and the lw shows ex_reg_write=0.
- Flush priority: flush=1 during a stall cycle, and flush=1 with a valid beq -> ex_valid=0. stall_count still increments on the stall cycle.
- Illegal/saturation: opcode 0x3F -> ex_illegal=1, all controls 0. Forcing 65,540 stall cycles -> stall_count holds at 0xFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the 5-stage MIPS pipeline:
//   - opcode constants for the supported instruction subset
//   - ALU operation encodings passed from decode to EX
//   - instruction field bit positions
//   - ctrl_t, the control bundle carried down the pipeline (ID/EX, EX/MEM)
package mips_pkg;

  // Supported opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // ALU operation class handed to EX; FUNCT means "look at ex_funct"
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // Instruction field bit positions
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;

  // Control bundle. Field order is fixed so the bundle can be carried as
  // a plain vector across module boundaries.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/control_decode.sv
// control_decode
// Purely combinational main decoder: opcode -> control bundle.
// Ports:
//   opcode   in   instr[31:26]
//   rt, rd   in   register fields used to pick the destination
//   ctrl     out  ctrl_t bundle as a flat vector (illegal lives inside it)
//   dest     out  destination register, 0 when the instruction writes nothing
//   rt_used  out  1 when rt is a source operand (matters for hazard detection)
module control_decode
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [5:0]        opcode,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  output logic [CTRL_W-1:0] ctrl,
  output logic [REG_AW-1:0] dest,
  output logic              rt_used
);

  ctrl_t c;

  always_comb begin
    c       = '0;
    dest    = '0;
    rt_used = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        c.alu_op    = ALU_OP_FUNCT;
        c.reg_write = 1'b1;
        dest        = rd;
        rt_used     = 1'b1;
      end
      OP_LW: begin
        c.alu_op    = ALU_OP_ADD;
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
        dest        = rt;
      end
      OP_SW: begin
        c.alu_op    = ALU_OP_ADD;
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        rt_used     = 1'b1;
      end
      OP_BEQ: begin
        c.alu_op  = ALU_OP_SUB;
        c.branch  = 1'b1;
        rt_used   = 1'b1;
      end
      OP_ADDI: begin
        c.alu_op    = ALU_OP_ADD;
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        dest        = rt;
      end
      default: begin
        c.illegal = 1'b1;
      end
    endcase
    // $0 is hardwired zero: a write to it is never a real write
    if (dest == '0) begin
      c.reg_write = 1'b0;
    end
  end

  assign ctrl = c;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// Decode stage plus the ID/EX pipeline register.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   id_valid/id_instr/id_pc_plus4  instruction from IF/ID
//   flush                       branch squash from EX, kills the ID/EX entry
//   rf_read_reg1/2              rs/rt addresses to the register file (comb.)
//   rf_read_data1/2             returned operands (write-through bypassed)
//   stall                       load-use stall request to fetch (comb.)
//   ex_*                        registered ID/EX contents
//   stall_count                 saturating count of stall cycles
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [DATA_W-1:0]      id_instr,
  input  logic [DATA_W-1:0]      id_pc_plus4,
  input  logic                   flush,
  output logic [REG_AW-1:0]      rf_read_reg1,
  output logic [REG_AW-1:0]      rf_read_reg2,
  input  logic [DATA_W-1:0]      rf_read_data1,
  input  logic [DATA_W-1:0]      rf_read_data2,
  output logic                   stall,
  output logic                   ex_valid,
  output logic [DATA_W-1:0]      ex_pc_plus4,
  output logic [DATA_W-1:0]      ex_rs_data,
  output logic [DATA_W-1:0]      ex_rt_data,
  output logic [DATA_W-1:0]      ex_imm,
  output logic [REG_AW-1:0]      ex_rs,
  output logic [REG_AW-1:0]      ex_rt,
  output logic [REG_AW-1:0]      ex_dest,
  output logic [5:0]             ex_funct,
  output logic [1:0]             ex_alu_op,
  output logic                   ex_alu_src,
  output logic                   ex_reg_write,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic                   ex_branch,
  output logic                   ex_illegal,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

  // Field extraction
  logic [5:0]        id_opcode;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [5:0]        id_funct;
  logic [15:0]       id_imm16;
  logic [DATA_W-1:0] id_imm;

  assign id_opcode = id_instr[OPCODE_HI:OPCODE_LO];
  assign id_rs     = id_instr[RS_HI:RS_LO];
  assign id_rt     = id_instr[RT_HI:RT_LO];
  assign id_rd     = id_instr[RD_HI:RD_LO];
  assign id_funct  = id_instr[FUNCT_HI:FUNCT_LO];
  assign id_imm16  = id_instr[IMM_HI:IMM_LO];
  assign id_imm    = {{(DATA_W-16){id_imm16[15]}}, id_imm16};

  // Register-file addresses follow the instruction word even when it is
  // not valid; the read is harmless and keeps this path free of gating.
  assign rf_read_reg1 = id_rs;
  assign rf_read_reg2 = id_rt;

  // Main decode
  logic [CTRL_W-1:0] id_ctrl_bits;
  logic [REG_AW-1:0] id_dest;
  logic              id_rt_used;
  ctrl_t             id_ctrl;

  control_decode #(
    .REG_AW (REG_AW)
  ) u_control_decode (
    .opcode  (id_opcode),
    .rt      (id_rt),
    .rd      (id_rd),
    .ctrl    (id_ctrl_bits),
    .dest    (id_dest),
    .rt_used (id_rt_used)
  );

  assign id_ctrl = id_ctrl_bits;

  // ID/EX state
  logic                   ex_valid_d,    ex_valid_q;
  logic [DATA_W-1:0]      ex_pc_plus4_d, ex_pc_plus4_q;
  logic [DATA_W-1:0]      ex_rs_data_d,  ex_rs_data_q;
  logic [DATA_W-1:0]      ex_rt_data_d,  ex_rt_data_q;
  logic [DATA_W-1:0]      ex_imm_d,      ex_imm_q;
  logic [REG_AW-1:0]      ex_rs_d,       ex_rs_q;
  logic [REG_AW-1:0]      ex_rt_d,       ex_rt_q;
  logic [REG_AW-1:0]      ex_dest_d,     ex_dest_q;
  logic [5:0]             ex_funct_d,    ex_funct_q;
  ctrl_t                  ex_ctrl_d,     ex_ctrl_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d,   stall_cnt_q;

  // Load-use hazard: the load in EX has not produced data yet, so the
  // dependent instruction must wait one cycle. A load to $0 never counts.
  // rt only matters for instructions that actually read it.
  logic load_in_ex;
  logic rs_hit;
  logic rt_hit;

  assign load_in_ex = ex_valid_q & ex_ctrl_q.mem_read & (ex_dest_q != '0);
  assign rs_hit     = (ex_dest_q == id_rs);
  assign rt_hit     = id_rt_used & (ex_dest_q == id_rt);

  // Not gated by flush: fetch already gives flush priority over stall.
  assign stall = id_valid & load_in_ex & (rs_hit | rt_hit);

  // Next-state: bubble by default, capture only on a normal valid cycle.
  // The stall counter advances on every stall cycle, even a flushed one.
  always_comb begin
    ex_valid_d    = 1'b0;
    ex_pc_plus4_d = '0;
    ex_rs_data_d  = '0;
    ex_rt_data_d  = '0;
    ex_imm_d      = '0;
    ex_rs_d       = '0;
    ex_rt_d       = '0;
    ex_dest_d     = '0;
    ex_funct_d    = '0;
    ex_ctrl_d     = '0;
    stall_cnt_d   = stall_cnt_q;

    if (stall && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    if (!flush && !stall && id_valid) begin
      ex_valid_d    = 1'b1;
      ex_pc_plus4_d = id_pc_plus4;
      ex_rs_data_d  = rf_read_data1;
      ex_rt_data_d  = rf_read_data2;
      ex_imm_d      = id_imm;
      ex_rs_d       = id_rs;
      ex_rt_d       = id_rt;
      ex_dest_d     = id_dest;
      ex_funct_d    = id_funct;
      ex_ctrl_d     = id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_pc_plus4_q <= '0;
      ex_rs_data_q  <= '0;
      ex_rt_data_q  <= '0;
      ex_imm_q      <= '0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_dest_q     <= '0;
      ex_funct_q    <= '0;
      ex_ctrl_q     <= '0;
      stall_cnt_q   <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_plus4_q <= ex_pc_plus4_d;
      ex_rs_data_q  <= ex_rs_data_d;
      ex_rt_data_q  <= ex_rt_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_dest_q     <= ex_dest_d;
      ex_funct_q    <= ex_funct_d;
      ex_ctrl_q     <= ex_ctrl_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc_plus4  = ex_pc_plus4_q;
  assign ex_rs_data   = ex_rs_data_q;
  assign ex_rt_data   = ex_rt_data_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rs        = ex_rs_q;
  assign ex_rt        = ex_rt_q;
  assign ex_dest      = ex_dest_q;
  assign ex_funct     = ex_funct_q;
  assign ex_alu_op    = ex_ctrl_q.alu_op;
  assign ex_alu_src   = ex_ctrl_q.alu_src;
  assign ex_reg_write = ex_ctrl_q.reg_write;
  assign ex_mem_read  = ex_ctrl_q.mem_read;
  assign ex_mem_write = ex_ctrl_q.mem_write;
  assign ex_branch    = ex_ctrl_q.branch;
  assign ex_illegal   = ex_ctrl_q.illegal;
  assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Self-checking bench for id_ex_stage. A vector table drives one
// instruction per cycle; the expected ID/EX contents for each vector are
// pushed to a scoreboard queue and popped after the clock edge. A second
// instance with a 4-bit stall counter shares all inputs so that counter
// saturation can be observed in a short run.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        flush;
  logic [31:0] rf_read_data1;
  logic [31:0] rf_read_data2;

  logic [4:0]  rf_read_reg1, rf_read_reg2;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [5:0]  ex_funct;
  logic [1:0]  ex_alu_op;
  logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_illegal;
  logic [15:0] stall_count;

  // Outputs of the narrow-counter instance; only stall_count is checked
  logic [4:0]  s_rf_read_reg1, s_rf_read_reg2;
  logic        s_stall, s_ex_valid;
  logic [31:0] s_ex_pc_plus4, s_ex_rs_data, s_ex_rt_data, s_ex_imm;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_dest;
  logic [5:0]  s_ex_funct;
  logic [1:0]  s_ex_alu_op;
  logic        s_ex_alu_src, s_ex_reg_write, s_ex_mem_read, s_ex_mem_write;
  logic        s_ex_branch, s_ex_illegal;
  logic [3:0]  s_stall_count;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .flush(flush),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .stall(stall), .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_funct(ex_funct),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_illegal(ex_illegal), .stall_count(stall_count)
  );

  id_ex_stage #(.STALL_CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .flush(flush),
    .rf_read_reg1(s_rf_read_reg1), .rf_read_reg2(s_rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .stall(s_stall), .ex_valid(s_ex_valid), .ex_pc_plus4(s_ex_pc_plus4),
    .ex_rs_data(s_ex_rs_data), .ex_rt_data(s_ex_rt_data), .ex_imm(s_ex_imm),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_dest(s_ex_dest),
    .ex_funct(s_ex_funct), .ex_alu_op(s_ex_alu_op),
    .ex_alu_src(s_ex_alu_src), .ex_reg_write(s_ex_reg_write),
    .ex_mem_read(s_ex_mem_read), .ex_mem_write(s_ex_mem_write),
    .ex_branch(s_ex_branch), .ex_illegal(s_ex_illegal),
    .stall_count(s_stall_count)
  );

  // Control bundle as {alu_op[1:0], alu_src, reg_write, mem_read, mem_write, branch, illegal}
  localparam logic [7:0] C_NONE = 8'b00_0_0_0_0_0_0;
  localparam logic [7:0] C_R    = 8'b10_0_1_0_0_0_0;
  localparam logic [7:0] C_LW   = 8'b00_1_1_1_0_0_0;
  localparam logic [7:0] C_LW0  = 8'b00_1_0_1_0_0_0;
  localparam logic [7:0] C_SW   = 8'b00_1_0_0_1_0_0;
  localparam logic [7:0] C_BEQ  = 8'b01_0_0_0_0_1_0;
  localparam logic [7:0] C_ADDI = 8'b00_1_1_0_0_0_0;
  localparam logic [7:0] C_ILL  = 8'b00_0_0_0_0_0_1;

  localparam logic [31:0] I_ADD_3_1_2  = 32'h00221820;
  localparam logic [31:0] I_ADDI_5_0_M4 = 32'h2005FFFC;
  localparam logic [31:0] I_SW_5_8_1   = 32'hAC250008;
  localparam logic [31:0] I_LW_4_0_1   = 32'h8C240000;
  localparam logic [31:0] I_ADD_6_4_2  = 32'h00823020;
  localparam logic [31:0] I_ADDI_7_8_1 = 32'h21070001;
  localparam logic [31:0] I_ADDI_4_8_1 = 32'h21040001;
  localparam logic [31:0] I_LW_0_0_1   = 32'h8C200000;
  localparam logic [31:0] I_ADD_6_0_0  = 32'h00003020;
  localparam logic [31:0] I_BEQ_1_4    = 32'h10240004;
  localparam logic [31:0] I_BEQ_1_2    = 32'h10220004;
  localparam logic [31:0] I_ILLEGAL    = 32'hFC221234;
  localparam logic [31:0] I_LW_4_0_4   = 32'h8C840000;

  typedef struct {
    logic        valid;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        exp_stall;
    logic        exp_valid;
    logic [4:0]  exp_dest;
    logic [7:0]  exp_ctrl;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [5:0]  funct;
    logic [7:0]  ctrl;
    logic [15:0] count;
    logic [3:0]  small_count;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   model_count = 0;
  int   model_small = 0;

  function automatic vec_t mk(logic v, logic f, logic [31:0] instr,
                              logic s, logic ev, logic [4:0] dest,
                              logic [7:0] ctrl);
    vec_t r;
    r.valid = v; r.flush = f; r.instr = instr;
    r.pc = 32'h0; r.d1 = 32'h0; r.d2 = 32'h0;
    r.exp_stall = s; r.exp_valid = ev; r.exp_dest = dest; r.exp_ctrl = ctrl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one IF/ID entry, check the combinational outputs, and queue
  // the ID/EX contents it must produce after the next edge.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    id_valid      = v.valid;
    flush         = v.flush;
    id_instr      = v.instr;
    id_pc_plus4   = v.pc;
    rf_read_data1 = v.d1;
    rf_read_data2 = v.d2;
    #2;
    chk("stall", {31'b0, stall}, {31'b0, v.exp_stall});
    chk("rf_read_reg1", {27'b0, rf_read_reg1}, {27'b0, v.instr[25:21]});
    chk("rf_read_reg2", {27'b0, rf_read_reg2}, {27'b0, v.instr[20:16]});
    if (v.exp_stall) begin
      if (model_count < 65535) model_count++;
      if (model_small < 15) model_small++;
    end
    e = '{default: '0};
    if (v.exp_valid) begin
      e.valid   = 1'b1;
      e.pc      = v.pc;
      e.rs_data = v.d1;
      e.rt_data = v.d2;
      e.imm     = {{16{v.instr[15]}}, v.instr[15:0]};
      e.rs      = v.instr[25:21];
      e.rt      = v.instr[20:16];
      e.funct   = v.instr[5:0];
      e.dest    = v.exp_dest;
      e.ctrl    = v.exp_ctrl;
    end
    e.count       = 16'(model_count);
    e.small_count = 4'(model_small);
    sb.push_back(e);
  endtask

  task automatic compareExpected(input exp_t e);
    chk("ex_valid", {31'b0, ex_valid}, {31'b0, e.valid});
    chk("ex_pc_plus4", ex_pc_plus4, e.pc);
    chk("ex_rs_data", ex_rs_data, e.rs_data);
    chk("ex_rt_data", ex_rt_data, e.rt_data);
    chk("ex_imm", ex_imm, e.imm);
    chk("ex_rs", {27'b0, ex_rs}, {27'b0, e.rs});
    chk("ex_rt", {27'b0, ex_rt}, {27'b0, e.rt});
    chk("ex_dest", {27'b0, ex_dest}, {27'b0, e.dest});
    chk("ex_funct", {26'b0, ex_funct}, {26'b0, e.funct});
    chk("ex_ctrl", {24'b0, ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read,
                    ex_mem_write, ex_branch, ex_illegal}, {24'b0, e.ctrl});
    chk("stall_count", {16'b0, stall_count}, {16'b0, e.count});
    chk("stall_count_4bit", {28'b0, s_stall_count}, {28'b0, e.small_count});
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      compareExpected(e);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t z;
    vec_t v;

    // Reset held with a valid add presented: ID/EX must stay empty
    rst_n = 1'b0;
    id_valid = 1'b1; flush = 1'b0; id_instr = I_ADD_3_1_2;
    id_pc_plus4 = 32'h4; rf_read_data1 = 32'h11; rf_read_data2 = 32'h22;
    repeat (2) @(posedge clk);
    #1;
    z = '{default: '0};
    compareExpected(z);
    rst_n = 1'b1;

    // Sequence table; a stalled entry is listed twice because IF/ID holds
    vecs.push_back(mk(1, 0, I_ADD_3_1_2,   0, 1, 5'd3, C_R));
    vecs.push_back(mk(1, 0, I_ADDI_5_0_M4, 0, 1, 5'd5, C_ADDI));
    vecs.push_back(mk(1, 0, I_SW_5_8_1,    0, 1, 5'd0, C_SW));
    vecs.push_back(mk(1, 0, I_LW_4_0_1,    0, 1, 5'd4, C_LW));
    vecs.push_back(mk(1, 0, I_ADD_6_4_2,   1, 0, 5'd0, C_NONE));
    vecs.push_back(mk(1, 0, I_ADD_6_4_2,   0, 1, 5'd6, C_R));
    vecs.push_back(mk(1, 0, I_LW_4_0_1,    0, 1, 5'd4, C_LW));
    vecs.push_back(mk(1, 0, I_ADDI_7_8_1,  0, 1, 5'd7, C_ADDI));
    vecs.push_back(mk(1, 0, I_LW_4_0_1,    0, 1, 5'd4, C_LW));
    vecs.push_back(mk(1, 0, I_ADDI_4_8_1,  0, 1, 5'd4, C_ADDI));
    vecs.push_back(mk(1, 0, I_LW_0_0_1,    0, 1, 5'd0, C_LW0));
    vecs.push_back(mk(1, 0, I_ADD_6_0_0,   0, 1, 5'd6, C_R));
    vecs.push_back(mk(1, 0, I_LW_4_0_1,    0, 1, 5'd4, C_LW));
    vecs.push_back(mk(1, 1, I_BEQ_1_4,     1, 0, 5'd0, C_NONE));
    vecs.push_back(mk(1, 0, I_BEQ_1_4,     0, 1, 5'd0, C_BEQ));
    vecs.push_back(mk(1, 1, I_BEQ_1_2,     0, 0, 5'd0, C_NONE));
    vecs.push_back(mk(1, 0, I_ILLEGAL,     0, 1, 5'd0, C_ILL));
    vecs.push_back(mk(0, 0, I_ADD_3_1_2,   0, 0, 5'd0, C_NONE));
    vecs.push_back(mk(1, 0, I_LW_4_0_1,    0, 1, 5'd4, C_LW));
    vecs.push_back(mk(0, 0, I_ADD_6_4_2,   0, 0, 5'd0, C_NONE));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      v.pc = 32'h0000_0400 + 32'(4 * i);
      v.d1 = 32'h1000_0000 + 32'(i);
      v.d2 = 32'h2000_0000 + 32'(3 * i);
      applyStimulus(v);
      checkOutput();
    end

    // Back-to-back lw $4,0($4): every second cycle stalls, enough to
    // saturate the 4-bit counter while the 16-bit one keeps counting.
    for (int i = 0; i <= 40; i++) begin
      v = mk(1, 0, I_LW_4_0_4, i[0], !i[0], 5'd4, C_LW);
      v.pc = 32'h0000_0800 + 32'(4 * i);
      v.d1 = 32'hA000_0000 ^ 32'(i);
      v.d2 = 32'hB000_0000 ^ 32'(7 * i);
      applyStimulus(v);
      checkOutput();
    end
    chk("stall_count_total", {16'b0, stall_count}, 32'd22);
    chk("stall_count_4bit_sat", {28'b0, s_stall_count}, 32'hF);

    // Reset asserted between edges clears ID/EX and the counters at once
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("async_rst_ex_dest", {27'b0, ex_dest}, 32'd0);
    chk("async_rst_ex_mem_read", {31'b0, ex_mem_read}, 32'd0);
    chk("async_rst_stall_count", {16'b0, stall_count}, 32'd0);
    chk("async_rst_stall_count_4bit", {28'b0, s_stall_count}, 32'd0);
    model_count = 0;
    model_small = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First edge after release behaves normally
    v = mk(1, 0, I_ADD_3_1_2, 0, 1, 5'd3, C_R);
    v.pc = 32'h0000_0C04; v.d1 = 32'h5555_AAAA; v.d2 = 32'h0F0F_F0F0;
    applyStimulus(v);
    checkOutput();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
